uart_txrx_p: RTL

Parametrised full-duplex UART for the ICB peripheral bus: register-mapped control, 16-bit baud divider, oversampled receiver with parity/frame/overrun detection, and a transmitter with configurable data width, parity and stop bits. Single clock domain; the baud rate comes from internal dividers, not from a separate baud clock. It is the successor to the TX-only UART and is the block the interrupt controller and the bus decoder connect to.

---
 rtl/uart_txrx_p.sv | 239 +++++++++++++++++++++++
 1 files changed

// File: rtl/uart_txrx_p.sv
// rtl/uart_txrx_p.sv - full-duplex UART with register-mapped control, baud divider and oversampled receiver
module uart_txrx_p #(
    parameter int DATA_W = 8,
    parameter int DIV_W  = 16,
    parameter int OSR    = 16
) (
    input  logic              sys_clk,
    input  logic              sys_rstn,
    input  logic              uart_con_wr,
    input  logic              uart_baud_wr,
    input  logic              uart_txbuf_wr,
    input  logic              uart_rxbuf_rd,
    input  logic [15:0]       icb_wdat,
    input  logic              uart_rx,
    output logic [15:0]       uart_con,
    output logic [DIV_W-1:0]  uart_baud,
    output logic [15:0]       uart_rxbuf,
    output logic              uart_tx,
    output logic              uart_int
);

    localparam int OSR_W = $clog2(OSR);
    localparam int CNT_W = $clog2(DATA_W + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);
    localparam logic [OSR_W-1:0] OSR_LAST = OSR_W'(OSR - 1);
    localparam logic [OSR_W-1:0] OSR_HALF = OSR_W'(OSR / 2 - 1);

    typedef enum logic [2:0] {ST_IDLE, ST_START, ST_DATA, ST_PARITY, ST_STOP} state_t;

    logic en, txie, rxie, prty_en, prty_odd, stop2;
    logic txpnd, rxpnd, ovr, err;

    state_t             tx_state, tx_next;
    logic [CNT_W-1:0]   tx_cnt, tx_cnt_nxt;
    logic [DIV_W-1:0]   tx_div;
    logic [OSR_W-1:0]   tx_osr;
    logic [DATA_W-1:0]  tx_data, tx_shift;
    logic               tx_tick, tx_bit_end, tx_start, tx_done, tx_line_nxt;
    logic [CNT_W-1:0]   stop_last;

    state_t             rx_state, rx_next;
    logic [CNT_W-1:0]   rx_cnt, rx_cnt_nxt;
    logic [DIV_W-1:0]   rx_div;
    logic [OSR_W-1:0]   rx_osr;
    logic [DATA_W-1:0]  rx_data;
    logic               rx_s1, rx_s2, rx_d, rx_fall, rx_perr;
    logic               rx_tick, rx_sample, rx_done, rx_clr;

    always_ff @(posedge sys_clk or negedge sys_rstn) begin
        if (!sys_rstn) begin
            {stop2, prty_odd, prty_en, rxie, txie, en} <= '0;
            uart_baud <= '0;
        end else begin
            if (uart_con_wr)
                {stop2, prty_odd, prty_en, rxie, txie, en} <= icb_wdat[5:0];
            if (uart_baud_wr)
                uart_baud <= icb_wdat[DIV_W-1:0];
        end
    end

    assign stop_last  = {{(CNT_W-1){1'b0}}, stop2};
    assign tx_tick    = (tx_div == uart_baud);
    assign tx_bit_end = tx_tick && (tx_osr == OSR_LAST);
    assign tx_start   = uart_txbuf_wr && en && (tx_state == ST_IDLE);

    always_comb begin
        tx_next     = tx_state;
        tx_cnt_nxt  = tx_cnt;
        tx_done     = 1'b0;
        tx_line_nxt = 1'b1;
        if (!en) begin
            tx_next    = ST_IDLE;
            tx_cnt_nxt = '0;
        end else begin
            case (tx_state)
                ST_IDLE:   if (uart_txbuf_wr) tx_next = ST_START;
                ST_START:  if (tx_bit_end) begin
                               tx_next    = ST_DATA;
                               tx_cnt_nxt = '0;
                           end
                ST_DATA:   if (tx_bit_end) begin
                               if (tx_cnt == CNT_LAST) begin
                                   tx_next    = prty_en ? ST_PARITY : ST_STOP;
                                   tx_cnt_nxt = '0;
                               end else begin
                                   tx_cnt_nxt = tx_cnt + 1'b1;
                               end
                           end
                ST_PARITY: if (tx_bit_end) tx_next = ST_STOP;
                ST_STOP:   if (tx_bit_end) begin
                               if (tx_cnt == stop_last) begin
                                   tx_next    = ST_IDLE;
                                   tx_cnt_nxt = '0;
                                   tx_done    = 1'b1;
                               end else begin
                                   tx_cnt_nxt = tx_cnt + 1'b1;
                               end
                           end
                default:   tx_next = ST_IDLE;
            endcase
        end
        // The serial line is registered, so it is derived from the upcoming state.
        tx_shift = tx_data >> tx_cnt_nxt;
        case (tx_next)
            ST_START:  tx_line_nxt = 1'b0;
            ST_DATA:   tx_line_nxt = tx_shift[0];
            ST_PARITY: tx_line_nxt = (^tx_data) ^ prty_odd;
            default:   tx_line_nxt = 1'b1;
        endcase
    end

    always_ff @(posedge sys_clk or negedge sys_rstn) begin
        if (!sys_rstn) begin
            tx_state <= ST_IDLE;
            tx_cnt   <= '0;
            tx_div   <= '0;
            tx_osr   <= '0;
            tx_data  <= '0;
            uart_tx  <= 1'b1;
            txpnd    <= 1'b0;
        end else begin
            tx_state <= tx_next;
            tx_cnt   <= tx_cnt_nxt;
            uart_tx  <= tx_line_nxt;
            if (tx_start)
                tx_data <= icb_wdat[DATA_W-1:0];
            if (!en || tx_state == ST_IDLE) begin
                tx_div <= '0;
                tx_osr <= '0;
            end else if (tx_tick) begin
                tx_div <= '0;
                tx_osr <= tx_bit_end ? '0 : tx_osr + 1'b1;
            end else begin
                tx_div <= tx_div + 1'b1;
            end
            if (tx_done)
                txpnd <= 1'b1;
            else if (tx_start || (uart_con_wr && icb_wdat[10]))
                txpnd <= 1'b0;
        end
    end

    assign rx_fall   = rx_d && !rx_s2;
    assign rx_tick   = (rx_div == uart_baud);
    assign rx_sample = rx_tick && (rx_osr == ((rx_state == ST_START) ? OSR_HALF : OSR_LAST));
    assign rx_clr    = uart_rxbuf_rd || (uart_con_wr && icb_wdat[11]);

    always_comb begin
        rx_next    = rx_state;
        rx_cnt_nxt = rx_cnt;
        rx_done    = 1'b0;
        if (!en) begin
            rx_next    = ST_IDLE;
            rx_cnt_nxt = '0;
        end else begin
            case (rx_state)
                ST_IDLE:   if (rx_fall) rx_next = ST_START;
                ST_START:  if (rx_sample) begin
                               rx_next    = rx_s2 ? ST_IDLE : ST_DATA;
                               rx_cnt_nxt = '0;
                           end
                ST_DATA:   if (rx_sample) begin
                               if (rx_cnt == CNT_LAST) begin
                                   rx_next    = prty_en ? ST_PARITY : ST_STOP;
                                   rx_cnt_nxt = '0;
                               end else begin
                                   rx_cnt_nxt = rx_cnt + 1'b1;
                               end
                           end
                ST_PARITY: if (rx_sample) rx_next = ST_STOP;
                ST_STOP:   if (rx_sample) begin
                               rx_next = ST_IDLE;
                               rx_done = 1'b1;
                           end
                default:   rx_next = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rstn) begin
        if (!sys_rstn) begin
            rx_s1      <= 1'b1;
            rx_s2      <= 1'b1;
            rx_d       <= 1'b1;
            rx_state   <= ST_IDLE;
            rx_cnt     <= '0;
            rx_div     <= '0;
            rx_osr     <= '0;
            rx_data    <= '0;
            rx_perr    <= 1'b0;
            rxpnd      <= 1'b0;
            ovr        <= 1'b0;
            err        <= 1'b0;
            uart_rxbuf <= '0;
        end else begin
            rx_s1    <= uart_rx;
            rx_s2    <= rx_s1;
            rx_d     <= rx_s2;
            rx_state <= rx_next;
            rx_cnt   <= rx_cnt_nxt;
            // The first sample happens half a bit in; later ones are a full bit apart.
            if (!en || rx_state == ST_IDLE) begin
                rx_div <= '0;
                rx_osr <= '0;
            end else if (rx_tick) begin
                rx_div <= '0;
                rx_osr <= rx_sample ? '0 : rx_osr + 1'b1;
            end else begin
                rx_div <= rx_div + 1'b1;
            end
            if (rx_state == ST_IDLE)
                rx_perr <= 1'b0;
            else if (rx_state == ST_PARITY && rx_sample)
                rx_perr <= rx_s2 ^ (^rx_data) ^ prty_odd;
            if (rx_state == ST_DATA && rx_sample)
                rx_data <= {rx_s2, rx_data[DATA_W-1:1]};
            if (rx_done && (!rxpnd || rx_clr))
                uart_rxbuf <= {{(16-DATA_W){1'b0}}, rx_data};
            if (rx_done)
                rxpnd <= 1'b1;
            else if (rx_clr)
                rxpnd <= 1'b0;
            if (rx_done && rxpnd && !rx_clr)
                ovr <= 1'b1;
            else if (uart_con_wr && icb_wdat[11])
                ovr <= 1'b0;
            if (rx_done && (!rx_s2 || rx_perr))
                err <= 1'b1;
            else if (uart_con_wr && icb_wdat[11])
                err <= 1'b0;
        end
    end

    assign uart_con = {err, ovr, rxpnd, txpnd, 4'b0000,
                       (rx_state != ST_IDLE), (tx_state != ST_IDLE),
                       stop2, prty_odd, prty_en, rxie, txie, en};
    assign uart_int = (txpnd && txie) || (rxpnd && rxie);

endmodule
